// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, operation codes and shifter selects for rv64_alu
package alu_pkg;
  localparam int XLEN = 64;
  localparam int SHAMT_W = 6;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLL  = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_t;
  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10
  } sh_op_t;
endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: left, logical-right and arithmetic-right shift by a 6-bit amount
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]    operand,
  input  logic [SHAMT_W-1:0] shamt,
  input  sh_op_t             sel,
  output logic [XLEN-1:0]    shifted
);
  logic signed [XLEN-1:0] sra_v;
  // arithmetic shift kept in its own signed expression so sign fill survives
  always_comb sra_v = $signed(operand) >>> shamt;
  // pick the shift flavour
  always_comb shifted = sel == SH_SLL ? operand << shamt :
                        sel == SH_SRA ? sra_v : operand >> shamt;
endmodule

// File: rtl/rv64_alu.sv
// rv64_alu: 64-bit RV64 ALU with registered result copy; ALU_OVF_EN adds ovf/ovf_q
module rv64_alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [XLEN-1:0] result_q,
  output logic            zero_q
`ifdef ALU_OVF_EN
  ,
  output logic            ovf,
  output logic            ovf_q
`endif
);
  logic [XLEN-1:0] sum, diff, shifted;
  logic            slt, sltu;
  sh_op_t          sh_sel;
  assign sum = rs1_data + rs2_data;
  assign diff = rs1_data - rs2_data;
  assign slt = $signed(rs1_data) < $signed(rs2_data);
  assign sltu = rs1_data < rs2_data;
  assign sh_sel = alu_ctrl == ALU_SLL ? SH_SLL : alu_ctrl == ALU_SRA ? SH_SRA : SH_SRL;
  alu_shifter u_shifter (
    .operand (rs1_data),
    .shamt   (rs2_data[SHAMT_W-1:0]),
    .sel     (sh_sel),
    .shifted (shifted)
  );
  // operation mux; unused codes resolve to zero so nothing goes X
  always_comb begin
    case (alu_ctrl)
      ALU_ADD:                   result = sum;
      ALU_SUB:                   result = diff;
      ALU_AND:                   result = rs1_data & rs2_data;
      ALU_OR:                    result = rs1_data | rs2_data;
      ALU_XOR:                   result = rs1_data ^ rs2_data;
      ALU_SLT:                   result = {{(XLEN-1){1'b0}}, slt};
      ALU_SLTU:                  result = {{(XLEN-1){1'b0}}, sltu};
      ALU_SLL, ALU_SRL, ALU_SRA: result = shifted;
      default:                   result = '0;
    endcase
  end
  assign zero = result == '0;
  // one-cycle registered copy of result and zero flag
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result;
      zero_q   <= zero;
    end
  end
`ifdef ALU_OVF_EN
  // signed overflow: add with like-signed operands, or sub with unlike-signed operands, flipping the sign
  always_comb ovf = alu_ctrl == ALU_ADD ? rs1_data[XLEN-1] == rs2_data[XLEN-1] && sum[XLEN-1] != rs1_data[XLEN-1] :
                    alu_ctrl == ALU_SUB ? rs1_data[XLEN-1] != rs2_data[XLEN-1] && diff[XLEN-1] != rs1_data[XLEN-1] :
                    1'b0;
  // registered overflow flag
  always_ff @(posedge clk) ovf_q <= rst ? 1'b0 : ovf;
`endif
endmodule

// File: tb/tb_rv64_alu.sv
// tb_rv64_alu: directed self-checking bench for rv64_alu
module tb_rv64_alu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] rs1_data = '0;
  logic [63:0] rs2_data = '0;
  logic [3:0]  alu_ctrl = '0;
  logic [63:0] result, result_q;
  logic        zero, zero_q;
`ifdef ALU_OVF_EN
  logic        ovf, ovf_q;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv64_alu dut (
    .clk      (clk),
    .rst      (rst),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .alu_ctrl (alu_ctrl),
    .result   (result),
    .zero     (zero),
    .result_q (result_q),
    .zero_q   (zero_q)
`ifdef ALU_OVF_EN
    ,
    .ovf      (ovf),
    .ovf_q    (ovf_q)
`endif
  );

  task automatic apply(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    alu_ctrl = c;
    rs1_data = a;
    rs2_data = b;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    apply(4'h0, 64'd5, 64'd10);
    @(posedge clk);
    #1;
    checks++;
    if (result_q !== 64'd0 || zero_q !== 1'b1) begin
      errors++;
      $display("FAIL reset: result_q=%h zero_q=%b expected 0 / 1", result_q, zero_q);
    end
`ifdef ALU_OVF_EN
    checks++;
    if (ovf_q !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf_q: got %b expected 0", ovf_q);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_add;
    logic [63:0] a[3] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5};
    logic [63:0] b[3] = '{64'd0, 64'd1, 64'd10};
    logic [63:0] r[3] = '{64'd0, 64'd0, 64'd15};
    logic        z[3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      apply(4'b0000, a[i], b[i]);
      checks++;
      if (result !== r[i] || zero !== z[i]) begin
        errors++;
        $display("FAIL add[%0d]: result=%h zero=%b expected %h / %b", i, result, zero, r[i], z[i]);
      end
    end
  endtask

  task automatic test_sub;
    logic [63:0] a[3] = '{64'd10, 64'd0, 64'd20};
    logic [63:0] b[3] = '{64'd10, 64'd1, 64'd5};
    logic [63:0] r[3] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd15};
    logic        z[3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      apply(4'b0001, a[i], b[i]);
      checks++;
      if (result !== r[i] || zero !== z[i]) begin
        errors++;
        $display("FAIL sub[%0d]: result=%h zero=%b expected %h / %b", i, result, zero, r[i], z[i]);
      end
    end
  endtask

  task automatic test_logic;
    logic [3:0]  c[3] = '{4'b0010, 4'b0011, 4'b0100};
    logic [63:0] r[3] = '{64'h0F0F_0000_0F0F_0000, 64'hFFFF_0F0F_FFFF_0F0F, 64'hF0F0_0F0F_F0F0_0F0F};
    for (int i = 0; i < 3; i++) begin
      apply(c[i], 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F);
      checks++;
      if (result !== r[i] || zero !== 1'b0) begin
        errors++;
        $display("FAIL logic[%0d]: result=%h zero=%b expected %h / 0", i, result, zero, r[i]);
      end
    end
  endtask

  task automatic test_compare;
    logic [3:0]  c[6] = '{4'b0101, 4'b0101, 4'b0101, 4'b1001, 4'b1001, 4'b1001};
    logic [63:0] a[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1};
    logic [63:0] b[6] = '{64'd1, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] r[6] = '{64'd1, 64'd0, 64'd0, 64'd0, 64'd1, 64'd1};
    logic        z[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      apply(c[i], a[i], b[i]);
      checks++;
      if (result !== r[i] || zero !== z[i]) begin
        errors++;
        $display("FAIL compare[%0d]: result=%h zero=%b expected %h / %b", i, result, zero, r[i], z[i]);
      end
    end
  endtask

  task automatic test_shift;
    logic [3:0]  c[9] = '{4'b0110, 4'b0110, 4'b0111, 4'b1000, 4'b1000, 4'b0110, 4'b0111, 4'b1000, 4'b1000};
    logic [63:0] a[9] = '{64'd1, 64'd1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                          64'hFFFF_FFFF_FFFF_FFF8, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                          64'h7000_0000_0000_0000, 64'h8000_0000_0000_0000};
    logic [63:0] b[9] = '{64'd0, 64'd63, 64'd63, 64'd4, 64'd2, 64'h41, 64'd4, 64'd4, 64'd63};
    logic [63:0] r[9] = '{64'd1, 64'h8000_0000_0000_0000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                          64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'h0FFF_FFFF_FFFF_FFFF,
                          64'h0700_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    for (int i = 0; i < 9; i++) begin
      apply(c[i], a[i], b[i]);
      checks++;
      if (result !== r[i] || zero !== 1'b0) begin
        errors++;
        $display("FAIL shift[%0d]: result=%h zero=%b expected %h / 0", i, result, zero, r[i]);
      end
    end
  endtask

  task automatic test_default;
    for (int i = 10; i < 16; i++) begin
      apply(4'(i), 64'h1234, 64'h5678);
      checks++;
      if (result !== 64'd0 || zero !== 1'b1) begin
        errors++;
        $display("FAIL default[%0d]: result=%h zero=%b expected 0 / 1", i, result, zero);
      end
    end
  endtask

  task automatic test_registered;
    apply(4'b0000, 64'd5, 64'd10);
    @(posedge clk);
    #1;
    checks++;
    if (result_q !== 64'd15 || zero_q !== 1'b0) begin
      errors++;
      $display("FAIL reg_add: result_q=%h zero_q=%b expected f / 0", result_q, zero_q);
    end
    apply(4'b0001, 64'd7, 64'd7);
    checks++;
    if (result_q !== 64'd15) begin
      errors++;
      $display("FAIL reg_hold: result_q=%h expected f before edge", result_q);
    end
    @(posedge clk);
    #1;
    checks++;
    if (result_q !== 64'd0 || zero_q !== 1'b1) begin
      errors++;
      $display("FAIL reg_zero: result_q=%h zero_q=%b expected 0 / 1", result_q, zero_q);
    end
    apply(4'b0000, 64'd20, 64'd22);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (result_q !== 64'd0 || zero_q !== 1'b1 || result !== 64'd42 || zero !== 1'b0) begin
      errors++;
      $display("FAIL reg_midrst: result_q=%h zero_q=%b result=%h zero=%b expected 0 / 1 / 2a / 0",
               result_q, zero_q, result, zero);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (result_q !== 64'd42 || zero_q !== 1'b0) begin
      errors++;
      $display("FAIL reg_release: result_q=%h zero_q=%b expected 2a / 0", result_q, zero_q);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a[4] = '{64'd3, 64'd9, 64'hF0, 64'd2};
    logic [63:0] b[4] = '{64'd4, 64'd9, 64'h0F, 64'd3};
    logic [3:0]  c[4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0110};
    logic [63:0] r[4] = '{64'd7, 64'd0, 64'hFF, 64'd16};
    for (int i = 0; i < 4; i++) begin
      apply(c[i], a[i], b[i]);
      @(posedge clk);
      #1;
      checks++;
      if (result_q !== r[i] || zero_q !== (r[i] == 64'd0)) begin
        errors++;
        $display("FAIL b2b[%0d]: result_q=%h zero_q=%b expected %h", i, result_q, zero_q, r[i]);
      end
    end
  endtask

`ifdef ALU_OVF_EN
  task automatic test_ovf;
    logic [3:0]  c[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0010};
    logic [63:0] a[6] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd5, 64'h8000_0000_0000_0000,
                          64'h8000_0000_0000_0000, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF};
    logic [63:0] b[6] = '{64'd1, 64'd10, 64'h8000_0000_0000_0000, 64'd1, 64'd1, 64'd1};
    logic        o[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      apply(c[i], a[i], b[i]);
      checks++;
      if (ovf !== o[i]) begin
        errors++;
        $display("FAIL ovf[%0d]: got %b expected %b", i, ovf, o[i]);
      end
      @(posedge clk);
      #1;
      checks++;
      if (ovf_q !== o[i]) begin
        errors++;
        $display("FAIL ovf_q[%0d]: got %b expected %b", i, ovf_q, o[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_add;
    test_sub;
    test_logic;
    test_compare;
    test_shift;
    test_default;
    test_registered;
    test_back_to_back;
`ifdef ALU_OVF_EN
    test_ovf;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
